// File: rtl/l2_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_mem_port_arbiter
//
// Shares the single L2-to-main-memory port between the instruction cache
// (requester 0) and the data cache (requester 1). Requests are arbitrated
// round-robin. Each winning request runs as a line burst of BURST_LEN 32-bit
// beats, and the memory paces the burst by toggling mem_stb. A requester is
// stalled while its request is outstanding.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   reqN, weN, addrN      level request, direction (1 = read line), line address
//   wdataN                write beat data, advanced by the requester on wackN
//   stallN                requester N has an outstanding request
//   rdata, rvalidN        read beat and its one-cycle valid for requester N
//   wackN                 one-cycle pulse: current wdataN was consumed
//   doneN, errN           one-cycle pulses: burst complete / strobe timeout
//   mem_req, mem_we       memory transaction active, copy of granted we
//   mem_addr, mem_beat    line-aligned address, current beat index
//   mem_wdata, mem_rdata  write / read beat to / from memory
//   mem_stb               beat strobe; every level change is one beat
// ---------------------------------------------------------------------------
module l2_mem_port_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req0,
    input  logic                         req1,
    input  logic                         we0,
    input  logic                         we1,
    input  logic [31:0]                  addr0,
    input  logic [31:0]                  addr1,
    input  logic [31:0]                  wdata0,
    input  logic [31:0]                  wdata1,
    output logic                         stall0,
    output logic                         stall1,
    output logic [31:0]                  rdata,
    output logic                         rvalid0,
    output logic                         rvalid1,
    output logic                         wack0,
    output logic                         wack1,
    output logic                         done0,
    output logic                         done1,
    output logic                         err0,
    output logic                         err1,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [$clog2(BURST_LEN)-1:0] mem_beat,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata,
    input  logic                         mem_stb
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_last_gnt;
    logic          r_gnt;
    logic          r_stb_q;
    logic [TW-1:0] r_tmo;

    logic w_req0;
    logic w_req1;
    logic w_pick_vld;
    logic w_pick;
    logic w_beat;
    logic w_last;
    logic w_tmo;
    logic w_fin0;
    logic w_fin1;
    logic w_unused_addr_lsbs;

    // A requester that is seeing its done/err pulse this cycle is not a new
    // request, even if it has not dropped req yet.
    assign w_req0 = req0 & ~done0 & ~err0;
    assign w_req1 = req1 & ~done1 & ~err1;

    assign w_beat = (r_state == ST_BURST) && (mem_stb != r_stb_q);
    assign w_last = w_beat && (mem_beat == BW'(BURST_LEN - 1));
    assign w_tmo  = (r_state == ST_BURST) && !w_beat && (r_tmo == TW'(TIMEOUT - 1));

    // Transaction of requester N ends at the coming edge (done or abort).
    assign w_fin0 = ((r_state == ST_DONE) || w_tmo) && !r_gnt;
    assign w_fin1 = ((r_state == ST_DONE) || w_tmo) &&  r_gnt;

    // Write data passes straight through so a word advanced on wack is on
    // the bus in time for the next beat, two clocks later at the earliest.
    assign mem_wdata = (r_state == ST_BURST) ? (r_gnt ? wdata1 : wdata0) : 32'd0;

    // Line offset bits are dropped on purpose.
    assign w_unused_addr_lsbs = ^{addr0[4:0], addr1[4:0]};

    // Round-robin pick between the two requesters.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = 1'b0;
        if (w_req0 && w_req1) begin
            w_pick_vld = 1'b1;
            w_pick     = ~r_last_gnt;
        end else if (w_req0) begin
            w_pick_vld = 1'b1;
            w_pick     = 1'b0;
        end else if (w_req1) begin
            w_pick_vld = 1'b1;
            w_pick     = 1'b1;
        end else begin
            w_pick_vld = 1'b0;
            w_pick     = 1'b0;
        end
    end

    // Stall tracks the request level, dropping together with done/err.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall0 <= 1'b0;
            stall1 <= 1'b0;
        end else begin
            stall0 <= req0 & ~w_fin0 & ~done0 & ~err0;
            stall1 <= req1 & ~w_fin1 & ~done1 & ~err1;
        end
    end

    // Arbitration and burst sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_stb_q    <= 1'b0;
            r_tmo      <= {TW{1'b0}};
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_beat   <= {BW{1'b0}};
            rdata      <= 32'd0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            wack0      <= 1'b0;
            wack1      <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            wack0   <= 1'b0;
            wack1   <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            // Sampled every clock; the ADDR sample is the burst's reference level.
            r_stb_q <= mem_stb;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt      <= w_pick;
                        r_last_gnt <= w_pick;
                        mem_we     <= w_pick ? we1 : we0;
                        mem_addr   <= w_pick ? {addr1[31:5], 5'b00000} : {addr0[31:5], 5'b00000};
                        mem_req    <= 1'b1;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    mem_beat <= {BW{1'b0}};
                    r_tmo    <= {TW{1'b0}};
                    r_state  <= ST_BURST;
                end
                ST_BURST: begin
                    if (w_beat) begin
                        r_tmo    <= {TW{1'b0}};
                        mem_beat <= mem_beat + BW'(1);
                        if (mem_we) begin
                            rdata <= mem_rdata;
                            if (r_gnt) rvalid1 <= 1'b1;
                            else       rvalid0 <= 1'b1;
                        end else begin
                            if (r_gnt) wack1 <= 1'b1;
                            else       wack0 <= 1'b1;
                        end
                        if (w_last) r_state <= ST_DONE;
                    end else if (w_tmo) begin
                        if (r_gnt) err1 <= 1'b1;
                        else       err0 <= 1'b1;
                        mem_req <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_DONE: begin
                    if (r_gnt) done1 <= 1'b1;
                    else       done0 <= 1'b1;
                    mem_req <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
